// File: rtl/apb_reg_slave.sv
// APB register slave: NUM_REGS 32-bit registers, the last one a read-only ID word.
// Define APB_REG_SLAVE_WAIT_EN to insert WAIT_CYCLES access-phase wait states per transfer.
module apb_reg_slave #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic [15:0] wr_count
);

    localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);
    localparam logic [IDX_W-1:0] RO_IDX = IDX_W'(NUM_REGS - 1);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACCESS = 1'b1;

`ifdef APB_REG_SLAVE_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
`else
    // Zero-wait build: the counter is always loaded with 0, so the first access cycle completes.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES) & 4'd0;
`endif

    logic              state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       regs_q [NUM_REGS-1];
    logic [31:0]       regs_d [NUM_REGS-1];
    logic [15:0]       wr_count_q, wr_count_d;

    logic [IDX_W-1:0]  idx;
    logic              addr_err;
    logic              ro_hit;
    logic              xfer_err;
    logic              setup_ph;
    logic              access_ph;
    logic              done;
    logic              viol;
    logic              commit;
    logic              wr_commit;
    logic [31:0]       rd_word;

    assign idx       = paddr[IDX_W+1:2];
    assign addr_err  = (paddr[1:0] != 2'b00) || (paddr >= ADDR_LIMIT);
    assign ro_hit    = (idx == RO_IDX);
    assign xfer_err  = addr_err || (pwrite && ro_hit);
    assign setup_ph  = psel && !penable;
    assign access_ph = psel && penable;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        viol    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup_ph) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WAIT_LOAD;
                end else if (access_ph) begin
                    // Access phase without a preceding setup: answer with an error, stay idle.
                    viol = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (penable) begin
                    if (cnt_q == 4'd0) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign commit    = done && !xfer_err;
    assign wr_commit = commit && pwrite && (pstrb != 4'b0000);

    always_comb begin
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_commit && (idx == IDX_W'(i))) begin
                for (int b = 0; b < 4; b++) begin
                    if (pstrb[b]) begin
                        regs_d[i][8*b +: 8] = pwdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign wr_count_d = wr_count_q + (wr_commit ? 16'd1 : 16'd0);

    always_comb begin
        rd_word = 32'h0;
        if (ro_hit) begin
            rd_word = ID_VALUE;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (idx == IDX_W'(i)) begin
                    rd_word = regs_q[i];
                end
            end
        end
    end

    // Responses are combinational; reset masks them so nothing leaks while areset is high.
    assign pready   = !areset && (done || viol);
    assign pslverr  = !areset && (viol || (done && xfer_err));
    assign prdata   = (!areset && done && !pwrite && !xfer_err) ? rd_word : 32'h0;
    assign wr_count = wr_count_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            wr_count_q <= 16'd0;
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_count_q <= wr_count_d;
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Randomized self-checking bench for apb_reg_slave against a register-map reference model.
// Honours APB_REG_SLAVE_WAIT_EN to select the expected number of wait states.
module tb_apb_reg_slave;

    localparam int          NUM_REGS    = 8;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [31:0] ID_VALUE    = 32'hA9B0_0001;
`ifdef APB_REG_SLAVE_WAIT_EN
    localparam int EXP_WAIT = WAIT_CYCLES;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        aclk;
    logic        areset;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [15:0] wr_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [NUM_REGS];
    logic [15:0] exp_wr_count;

    apb_reg_slave #(
        .NUM_REGS   (NUM_REGS),
        .WAIT_CYCLES(WAIT_CYCLES),
        .ID_VALUE   (ID_VALUE)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pready  (pready),
        .prdata  (prdata),
        .pslverr (pslverr),
        .wr_count(wr_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] addr, input logic wr);
        return (addr[1:0] != 2'b00) || (addr >= 32'(NUM_REGS * 4)) ||
               (wr && ((addr >> 2) == 32'(NUM_REGS - 1)));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (model_err(addr, 1'b0)) return 32'h0;
        if ((addr >> 2) == 32'(NUM_REGS - 1)) return ID_VALUE;
        return mem[addr >> 2];
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (!model_err(addr, 1'b1) && strb != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem[addr >> 2][8*b +: 8] = data[8*b +: 8];
            exp_wr_count = exp_wr_count + 16'd1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) mem[i] = 32'h0;
        exp_wr_count = 16'd0;
    endtask

    // Full transfer; returns in the pready cycle so a following call starts back-to-back.
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rdata);
        int   waits;
        logic got;
        @(posedge aclk) #1;
        paddr = addr; pwrite = wr; pwdata = data; pstrb = strb; psel = 1'b1; penable = 1'b0;
        @(negedge aclk);
        check("setup_pready", pready, 1'b0);
        check("wr_count", wr_count, exp_wr_count);
        @(posedge aclk) #1;
        penable = 1'b1;
        waits = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge aclk);
            if (pready) got = 1'b1;
            else begin
                check("wait_prdata", prdata, 32'h0);
                waits++;
            end
        end
        rdata = prdata;
        if (!got) begin
            check("timeout_pready", 32'h0, 32'h1);
            @(posedge aclk) #1;
            psel = 1'b0; penable = 1'b0;
            return;
        end
        check("wait_states", waits, EXP_WAIT);
        check("pslverr", pslverr, model_err(addr, wr));
        check("prdata", prdata, wr ? 32'h0 : model_read(addr));
        if (wr) model_write(addr, data, strb);
    endtask

    task automatic apb_idle(input int n);
        @(posedge aclk) #1;
        psel = 1'b0; penable = 1'b0;
        for (int i = 1; i < n; i++) @(posedge aclk);
        @(negedge aclk);
        check("idle_pready", pready, 1'b0);
        check("idle_wr_count", wr_count, exp_wr_count);
    endtask

    task automatic apb_abort(input logic [31:0] addr, input logic [31:0] data, input int n_access);
        @(posedge aclk) #1;
        paddr = addr; pwrite = 1'b1; pwdata = data; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
        for (int i = 0; i < n_access; i++) begin
            @(posedge aclk) #1;
            penable = 1'b1;
            @(negedge aclk);
            check("abort_pready", pready, 1'b0);
        end
        @(posedge aclk) #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge aclk);
        check("abort_pready_off", pready, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got 0x00000000 want 0x00000001");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        areset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
        model_reset();
        #1;
        check("rst_pready", pready, 1'b0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_wr_count", wr_count, 16'h0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;

        apb_xfer(32'h4, 1'b1, 32'hDEADBEEF, 4'b1110, rd);
        apb_xfer(32'h4, 1'b0, 32'h0, 4'h0, rd);
        check("d029_data", rd, 32'hDEADBE00);
        apb_idle(1);
        check("d029_wr_count", wr_count, 16'd1);

        apb_xfer(32'h8, 1'b1, 32'hAAAABBBB, 4'b1100, rd);
        apb_xfer(32'hC, 1'b1, 32'hCDCDCDCD, 4'b1000, rd);
        apb_xfer(32'h8, 1'b0, 32'h0, 4'h0, rd);
        check("d030_r8", rd, 32'hAAAA0000);
        apb_xfer(32'hC, 1'b0, 32'h0, 4'h0, rd);
        check("d030_rc", rd, 32'hCD000000);
        apb_xfer(32'h10, 1'b0, 32'h0, 4'h0, rd);
        check("d030_r10", rd, 32'h0);
        apb_xfer(32'h10, 1'b1, 32'h12345678, 4'b0000, rd);
        apb_idle(2);

        apb_xfer(32'h20, 1'b0, 32'h0, 4'h0, rd);
        apb_xfer(32'h1C, 1'b1, 32'h11111111, 4'hF, rd);
        apb_xfer(32'h6, 1'b1, 32'h22222222, 4'hF, rd);
        apb_xfer(32'h1C, 1'b0, 32'h0, 4'h0, rd);
        check("d032_id", rd, 32'hA9B00001);
        apb_xfer(32'h4, 1'b0, 32'h0, 4'h0, rd);
        check("d032_r4", rd, 32'hDEADBE00);
        apb_idle(1);

        // Access phase with no setup while idle
        @(posedge aclk) #1;
        paddr = 32'h8; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; psel = 1'b1; penable = 1'b1;
        @(negedge aclk);
        check("viol_pready", pready, 1'b1);
        check("viol_pslverr", pslverr, 1'b1);
        check("viol_prdata", prdata, 32'h0);
        apb_idle(1);
        apb_xfer(32'h8, 1'b0, 32'h0, 4'h0, rd);
        check("viol_r8", rd, 32'hAAAA0000);
        apb_idle(1);

        apb_abort(32'h8, 32'h55555555, 0);
        apb_abort(32'h8, 32'h66666666, (EXP_WAIT > 0) ? 1 : 0);
        apb_idle(1);
        check("abort_wr_count", wr_count, 16'd3);
        apb_xfer(32'h8, 1'b0, 32'h0, 4'h0, rd);
        check("abort_r8", rd, 32'hAAAA0000);
        apb_idle(1);

        // Reset in the middle of a write to 0x4
        @(posedge aclk) #1;
        paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
        @(posedge aclk) #1;
        penable = 1'b1;
        #2;
        areset = 1'b1;
        #1;
        check("midrst_pready", pready, 1'b0);
        check("midrst_pslverr", pslverr, 1'b0);
        check("midrst_prdata", prdata, 32'h0);
        psel = 1'b0; penable = 1'b0;
        model_reset();
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        check("midrst_wr_count", wr_count, 16'h0);
        apb_xfer(32'h4, 1'b0, 32'h0, 4'h0, rd);
        check("midrst_r4", rd, 32'h0);
        apb_xfer(32'h4, 1'b1, 32'h0BADF00D, 4'hF, rd);
        apb_xfer(32'h4, 1'b0, 32'h0, 4'h0, rd);
        check("midrst_r4_new", rd, 32'h0BADF00D);
        apb_idle(1);
        check("midrst_wr_count_new", wr_count, 16'd1);

        for (int t = 0; t < 120; t++) begin
            a = 32'($urandom_range(0, NUM_REGS * 4 + 7));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) a = $urandom;
            apb_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd);
            if ($urandom_range(0, 2) == 0) apb_idle($urandom_range(1, 3));
        end
        apb_idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
